// File: rtl/pio_serial_pkg.sv
// Shared types and field positions for the PIO-driven serial transmitter.
// The request entry mirrors the low nine bits of the PIO word.
package pio_serial_pkg;

    localparam int TOGGLE_BIT = 9;
    localparam int PAR_EN_BIT = 8;
    localparam int DATA_MSB   = 7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    typedef struct packed {
        logic                par_en;
        logic [DATA_MSB:0]   data;
    } req_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH   = 9,
    parameter int DEPTH   = 4,
    parameter int LEVEL_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   rdata,
    output logic [LEVEL_W-1:0] level,
    output logic               full,
    output logic               empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (level == LEVEL_W'(DEPTH));
    assign empty = (level == '0);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !rd_en)
                level <= level + 1'b1;
            else if (rd_en && !wr_en)
                level <= level - 1'b1;
        end
    end

    // Storage needs no reset: the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pio_serial_tx.sv
// Turns toggle-tagged PIO words into queued UART frames on tx.
// Optional even parity per request; frames run back-to-back when queued.
module pio_serial_tx
    import pio_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4,
    parameter int LEVEL_W      = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         pio_word,
    input  logic               clear_ovf,
    output logic               tx,
    output logic               busy,
    output logic [LEVEL_W-1:0] fifo_level,
    output logic               overflow
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    state_t           state;
    state_t           state_nxt;
    logic             prev_toggle;
    logic             req;
    logic             pop;
    logic             push_ok;
    logic             full;
    logic             empty;
    logic [8:0]       head_raw;
    req_t             head;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic             bit_end;
    logic [7:0]       shift;
    logic             par_en;
    logic             parity;
    logic [LEVEL_W-1:0] lvl_nxt;

    assign req     = pio_word[TOGGLE_BIT] ^ prev_toggle;
    assign push_ok = req && (!full || pop);
    assign bit_end = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign head    = req_t'(head_raw);
    assign lvl_nxt = fifo_level + LEVEL_W'(push_ok) - LEVEL_W'(pop);

    sync_fifo #(
        .WIDTH   (9),
        .DEPTH   (FIFO_DEPTH),
        .LEVEL_W (LEVEL_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req),
        .pop   (pop),
        .wdata (pio_word[PAR_EN_BIT:0]),
        .rdata (head_raw),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = START;
                    pop       = 1'b1;
                end
            end
            START: if (bit_end) state_nxt = DATA;
            DATA: begin
                if (bit_end && bit_cnt == 3'd7)
                    state_nxt = par_en ? PARITY : STOP;
            end
            PARITY: if (bit_end) state_nxt = STOP;
            STOP: begin
                if (bit_end) begin
                    state_nxt = empty ? IDLE : START;
                    pop       = !empty;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        unique case (state)
            START:   tx = 1'b0;
            DATA:    tx = shift[0];
            PARITY:  tx = parity;
            default: tx = 1'b1;
        endcase
    end

    // Toggle history follows the pin even in reset, so release never fires.
    always_ff @(posedge clk) begin
        prev_toggle <= pio_word[TOGGLE_BIT];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_en   <= 1'b0;
            parity   <= 1'b0;
        end else begin
            if (state == IDLE || bit_end)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;
            if (state == DATA && bit_end) begin
                bit_cnt <= bit_cnt + 1'b1;
                shift   <= shift >> 1;
            end
            if (pop) begin
                shift  <= head.data;
                par_en <= head.par_en;
                parity <= ^head.data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE) || (lvl_nxt != '0);
            if (clear_ovf)
                overflow <= 1'b0;
            else if (req && full && !pop)
                overflow <= 1'b1;
        end
    end

endmodule
